// File: rtl/loop_over_all_nibbles.sv
// Nibble-serial 32-bit ALU: ADD/SUB/AND/OR/XOR/COMP, one 4-bit slice per clock, LSB first.
// Optional macro ALU_EARLY_CARRY_STOP_EN enables early termination of ADD/SUB.
module loop_over_all_nibbles (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        loop_perm_to_count,
  input  logic [4:0]  ctrl,
  input  logic [2:0]  loop_nibbles_number,
  input  logic        word2_is_signed_and_negative,
  input  logic [31:0] word1,
  input  logic [31:0] word2,
  input  logic [31:0] preinit_result,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_COMP} op_t;

  state_t      state_q, state_nxt;
  op_t         op_q, op_dec;
  logic [31:0] w1_q, w2_q, w2_eff;
  logic        carry_q;
  logic [2:0]  idx_q;
  logic        nz_q;
  logic [3:0]  nib_a, nib_b, nib_res;
  logic [4:0]  sum5;
  logic        last, stop, start;
  logic        fill_bit;

`ifdef ALU_EARLY_CARRY_STOP_EN
  logic [2:0]  n_q;
  logic        fill_q;
`endif

  always_comb begin
    op_dec = OP_ADD;
    unique case (ctrl[2:0])
      3'd1:    op_dec = OP_SUB;
      3'd2:    op_dec = OP_AND;
      3'd3:    op_dec = OP_OR;
      3'd4:    op_dec = OP_XOR;
      3'd5:    op_dec = OP_COMP;
      default: op_dec = OP_ADD;
    endcase
  end

  // Nibbles above loop_nibbles_number take the fill value; SUB/COMP store word2 inverted.
  always_comb begin
    w2_eff = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      if (j <= 32'(loop_nibbles_number))
        w2_eff[4*j +: 4] = word2[4*j +: 4];
      else
        w2_eff[4*j +: 4] = {4{word2_is_signed_and_negative}};
    end
    if (op_dec == OP_SUB || op_dec == OP_COMP)
      w2_eff = ~w2_eff;
  end

  assign fill_bit = word2_is_signed_and_negative ^ (op_dec == OP_SUB);
  assign start    = (state_q == IDLE) && loop_perm_to_count;

  always_comb begin
    nib_a   = w1_q[{idx_q, 2'b00} +: 4];
    nib_b   = w2_q[{idx_q, 2'b00} +: 4];
    sum5    = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, carry_q};
    nib_res = sum5[3:0];
    unique case (op_q)
      OP_AND:  nib_res = nib_a & nib_b;
      OP_OR:   nib_res = nib_a | nib_b;
      OP_XOR:  nib_res = nib_a ^ nib_b;
      default: nib_res = sum5[3:0];
    endcase
  end

  assign last = (idx_q == 3'd7);

`ifdef ALU_EARLY_CARRY_STOP_EN
  assign stop = last || ((op_q == OP_ADD || op_q == OP_SUB) &&
                         (idx_q >= n_q) && (sum5[4] == fill_q));
`else
  assign stop = last;
`endif

  always_comb begin
    state_nxt = state_q;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = loop_perm_to_count;
        if (loop_perm_to_count) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (stop) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      nz_q    <= 1'b0;
      op_q    <= OP_ADD;
      w1_q    <= '0;
      w2_q    <= '0;
`ifdef ALU_EARLY_CARRY_STOP_EN
      n_q     <= '0;
      fill_q  <= 1'b0;
`endif
    end else if (start) begin
      op_q    <= op_dec;
      w1_q    <= word1;
      w2_q    <= w2_eff;
      result  <= preinit_result;
      idx_q   <= '0;
      nz_q    <= 1'b0;
      carry_q <= (op_dec == OP_SUB || op_dec == OP_COMP);
`ifdef ALU_EARLY_CARRY_STOP_EN
      n_q     <= loop_nibbles_number;
      fill_q  <= fill_bit;
`endif
    end else if (state_q == RUN) begin
      idx_q   <= idx_q + 3'd1;
      carry_q <= sum5[4];
      if (op_q == OP_COMP) begin
        nz_q <= nz_q | (sum5[3:0] != 4'h0);
        // Final nibble: flags replace the whole result (eq, ltu = no final carry).
        if (last)
          result <= {30'b0, ~(nz_q | (sum5[3:0] != 4'h0)), ~sum5[4]};
      end else begin
        result[{idx_q, 2'b00} +: 4] <= nib_res;
      end
    end
  end

`ifndef ALU_EARLY_CARRY_STOP_EN
  logic unused_fill;
  assign unused_fill = fill_bit;
`endif

endmodule

// File: tb/tb_loop_over_all_nibbles.sv
// Self-checking bench for loop_over_all_nibbles: directed plan cases, handshake, reset and random ops
// against a word-level arithmetic reference model.
module tb_loop_over_all_nibbles;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        loop_perm_to_count = 1'b0;
  logic [4:0]  ctrl = '0;
  logic [2:0]  loop_nibbles_number = '0;
  logic        word2_is_signed_and_negative = 1'b0;
  logic [31:0] word1 = '0, word2 = '0, preinit_result = '0;
  logic [31:0] result;
  logic        busy;

  int errors = 0;
  int checks = 0;

  loop_over_all_nibbles dut (
    .clk(clk), .rst_n(rst_n), .loop_perm_to_count(loop_perm_to_count), .ctrl(ctrl),
    .loop_nibbles_number(loop_nibbles_number),
    .word2_is_signed_and_negative(word2_is_signed_and_negative),
    .word1(word1), .word2(word2), .preinit_result(preinit_result),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word-level reference: effective operand by masking, then plain 32-bit arithmetic.
  function automatic void model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] n, input logic neg, input logic [31:0] pre,
                                output logic [31:0] res, output int k);
    logic [31:0] mask, w2e;
    int top;
    top  = 4 * (int'(n) + 1);
    mask = (n == 3'd7) ? 32'hFFFF_FFFF : ((32'd1 << top) - 32'd1);
    w2e  = (b & mask) | (neg ? ~mask : 32'h0);
    k    = 8;
    case (c[2:0])
      3'd1:    res = a - w2e;
      3'd2:    res = a & w2e;
      3'd3:    res = a | w2e;
      3'd4:    res = a ^ w2e;
      3'd5:    res = {30'b0, a == w2e, a < w2e};
      default: res = a + w2e;
    endcase
`ifdef ALU_EARLY_CARRY_STOP_EN
    if (!(c[2:0] inside {3'd2, 3'd3, 3'd4, 3'd5})) begin
      logic sub;
      logic [31:0] bb;
      logic [63:0] m, co;
      sub = (c[2:0] == 3'd1);
      bb  = sub ? ~w2e : w2e;
      for (int i = int'(n); i < 8; i++) begin
        m  = (64'd1 << (4 * (i + 1))) - 64'd1;
        co = ((({32'b0, a} & m) + ({32'b0, bb} & m) + {63'b0, sub}) >> (4 * (i + 1))) & 64'd1;
        if (co[0] == (neg ^ sub)) begin
          k   = i + 1;
          res = (res & m[31:0]) | (pre & ~m[31:0]);
          break;
        end
      end
    end
`endif
  endfunction

  task automatic wait_done(input string tag, input int exp_k, input logic [31:0] exp_res);
    int cyc;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
      if (!busy) break;
    end
    chk({tag, "_busy_cycles"}, 32'(cyc), 32'(1 + exp_k));
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_done_busy"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [4:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] n, input logic neg,
                        input logic [31:0] pre, input logic [31:0] exp_res, input bit hold);
    logic [31:0] mres;
    int k;
    model(c, a, b, n, neg, pre, mres, k);
    @(negedge clk);
    ctrl = c; word1 = a; word2 = b; loop_nibbles_number = n;
    word2_is_signed_and_negative = neg; preinit_result = pre;
    loop_perm_to_count = 1'b1;
    #1;
    chk({tag, "_start_busy"}, {31'b0, busy}, 32'd1);
    // Scramble operands: they must be ignored after the start edge.
    @(posedge clk); #1;
    word1 = $urandom; word2 = $urandom; preinit_result = $urandom; ctrl = 5'd2;
    if (busy) wait_done(tag, k - 1, exp_res);
    else begin
      chk({tag, "_result"}, result, exp_res);
      chk({tag, "_busy_cycles"}, 32'd1, 32'(1 + k));
    end
    if (hold) begin
      ctrl = c; word1 = a; word2 = b; preinit_result = pre;
      @(posedge clk); #1;
      chk({tag, "_restart_busy"}, {31'b0, busy}, 32'd1);
      wait_done({tag, "_b2b"}, k, exp_res);
    end
    loop_perm_to_count = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_idle_hold"}, result, exp_res);
  endtask

  initial begin
    logic [31:0] mres, ra, rb;
    logic [4:0]  rc;
    logic [2:0]  rn;
    logic        rneg;
    int k;

    #12;
    chk("reset_result", result, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("pc_inc", 5'd0, 32'h0000_00FF, 32'd4, 3'd0, 1'b0, 32'h0000_00FF, 32'h0000_0103, 1'b1);
    run_op("imm_add", 5'd0, 32'h7B, 32'd2, 3'd2, 1'b0, 32'h7B, 32'h0000_007D, 1'b0);
    run_op("imm_sgn", 5'd0, 32'h0, 32'h0000_0800, 3'd2, 1'b1, 32'h0, 32'hFFFF_F800, 1'b0);
    run_op("comp_lt", 5'd5, 32'd5, 32'd7, 3'd7, 1'b0, 32'hDEAD_BEEF, 32'h1, 1'b0);
    run_op("comp_eq", 5'd5, 32'd7, 32'd7, 3'd7, 1'b0, 32'h0, 32'h2, 1'b0);
    run_op("comp_gt", 5'd5, 32'hFFFF_FFFF, 32'd1, 3'd7, 1'b0, 32'h0, 32'h0, 1'b0);
    run_op("sub", 5'd1, 32'd5, 32'd7, 3'd7, 1'b0, 32'd5, 32'hFFFF_FFFE, 1'b0);
    run_op("and", 5'd2, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 3'd7, 1'b0, 32'h0, 32'h00F0_A5A5, 1'b0);
    run_op("or", 5'd3, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 3'd7, 1'b0, 32'h0, 32'hFFF0_FFFF, 1'b0);
    run_op("xor", 5'd4, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 3'd7, 1'b0, 32'h0, 32'hFF00_5A5A, 1'b0);
    run_op("code7_add", 5'd7, 32'h1234_5678, 32'h1111_1111, 3'd7, 1'b0, 32'h1234_5678,
           32'h2345_6789, 1'b0);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    ctrl = 5'd0; word1 = 32'h1; word2 = 32'h1; loop_nibbles_number = 3'd7;
    word2_is_signed_and_negative = 1'b0; preinit_result = 32'hCAFE_F00D;
    loop_perm_to_count = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    loop_perm_to_count = 1'b0;
    #1;
    chk("midrun_reset_busy", {31'b0, busy}, 32'd0);
    chk("midrun_reset_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_reset", 5'd1, 32'h100, 32'h1, 3'd0, 1'b0, 32'h100, 32'h0000_00FF, 1'b0);

    for (int t = 0; t < 30; t++) begin
      rc   = 5'($urandom_range(0, 7));
      ra   = $urandom;
      rb   = $urandom;
      rn   = 3'($urandom_range(0, 7));
      rneg = 1'($urandom_range(0, 1));
      if (t % 4 == 0) rb = ra;
      model(rc, ra, rb, rn, rneg, ra, mres, k);
      run_op($sformatf("rand%0d", t), rc, ra, rb, rn, rneg, ra, mres, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
